reg_scoreboard: RTL

Register hazard scoreboard for the single-issue CPU. It tracks which architectural registers have a pending write from an in-flight instruction and drives `is_full_rnum1` / `is_full_rnum2` into the control path. The control path uses those flags to insert a NOP stall. The block sits between instruction decode (issue side) and the control path (query side), one per core.

---
 rtl/reg_scoreboard_if.sv | 25 ++
 rtl/reg_scoreboard.sv | 87 ++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue/query bundle between decode, the control path and reg_scoreboard.
// The master drives issue and query inputs; the slave (scoreboard) returns hazard flags.
interface reg_scoreboard_if;
  logic       issue_valid;
  logic       issue_write;
  logic       issue_from_mem;
  logic [4:0] issue_rd;
  logic       flush;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       is_full_rnum1;
  logic       is_full_rnum2;
  logic       busy_any;
  logic [5:0] busy_count;

  modport master (
    output issue_valid, issue_write, issue_from_mem, issue_rd, flush, rs, rt,
    input  is_full_rnum1, is_full_rnum2, busy_any, busy_count
  );

  modport slave (
    input  issue_valid, issue_write, issue_from_mem, issue_rd, flush, rs, rt,
    output is_full_rnum1, is_full_rnum2, busy_any, busy_count
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard: per-register countdown of pending writes, combinational queries.
// Optional macro SCOREBOARD_BYPASS_EN hides a register's final pending cycle from the query flags.
module reg_scoreboard #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned ALU_LATENCY  = 2,
  parameter int unsigned LOAD_LATENCY = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb_if
);

  if (NREGS < 2 || NREGS > 32) begin : g_bad_nregs
    $error("NREGS must lie in 2..32");
  end
  if (ALU_LATENCY < 1 || ALU_LATENCY > (2 ** CNT_W) - 1) begin : g_bad_alu
    $error("ALU_LATENCY must lie in 1..2^CNT_W-1");
  end
  if (LOAD_LATENCY < 1 || LOAD_LATENCY > (2 ** CNT_W) - 1) begin : g_bad_load
    $error("LOAD_LATENCY must lie in 1..2^CNT_W-1");
  end

  logic [CNT_W-1:0] r_cnt   [NREGS];
  logic [CNT_W-1:0] w_cnt_d [NREGS];
  logic [NREGS-1:0] w_pend;
  logic [NREGS-1:0] w_flag;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_full1;
  logic             w_full2;
  logic [5:0]       w_count;

  assign w_load     = sb_if.issue_valid & sb_if.issue_write & (sb_if.issue_rd != 5'd0);
  assign w_load_val = sb_if.issue_from_mem ? CNT_W'(LOAD_LATENCY) : CNT_W'(ALU_LATENCY);

  // Flush beats issue; a load overrides the decrement and restarts a pending register.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      w_cnt_d[i] = (r_cnt[i] != '0) ? r_cnt[i] - CNT_W'(1) : '0;
      if (w_load && (32'(sb_if.issue_rd) == i)) begin
        w_cnt_d[i] = w_load_val;
      end
      if (sb_if.flush || (i == 0)) begin
        w_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  always_comb begin
    w_pend  = '0;
    w_flag  = '0;
    w_full1 = 1'b0;
    w_full2 = 1'b0;
    w_count = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      w_pend[i] = (r_cnt[i] != '0);
`ifdef SCOREBOARD_BYPASS_EN
      // Writeback forwarding covers the last pending cycle.
      w_flag[i] = (r_cnt[i] > CNT_W'(1));
`else
      w_flag[i] = w_pend[i];
`endif
      if (32'(sb_if.rs) == i) w_full1 = w_flag[i];
      if (32'(sb_if.rt) == i) w_full2 = w_flag[i];
      w_count = w_count + 6'(w_pend[i]);
    end
  end

  assign sb_if.is_full_rnum1 = w_full1;
  assign sb_if.is_full_rnum2 = w_full2;
  assign sb_if.busy_count    = w_count;
  assign sb_if.busy_any      = (w_count != 6'd0);

endmodule
